// File: rtl/maze_port_arbiter_if.sv
// Bus bundle between the maze lookup requesters/ROM and maze_port_arbiter.
// slave = arbiter side, master = requesters plus intersection ROM.
interface maze_port_arbiter_if;
    logic [3:0] req;
    logic [9:0] req_x0, req_x1, req_x2, req_x3;
    logic [9:0] req_y0, req_y1, req_y2, req_y3;
    logic [3:0] gnt;
    logic [3:0] rvalid;
    logic [3:0] rdata;
    logic       rom_en;
    logic [9:0] rom_x;
    logic [9:0] rom_y;
    logic [3:0] rom_data;
    logic       busy;

    modport slave (
        input  req, req_x0, req_x1, req_x2, req_x3,
               req_y0, req_y1, req_y2, req_y3, rom_data,
        output gnt, rvalid, rdata, rom_en, rom_x, rom_y, busy
    );

    modport master (
        output req, req_x0, req_x1, req_x2, req_x3,
               req_y0, req_y1, req_y2, req_y3, rom_data,
        input  gnt, rvalid, rdata, rom_en, rom_x, rom_y, busy
    );
endinterface

// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing one intersection ROM among pacman and three ghosts.
// Optional MAZE_ARB_BOUNDS_CHECK_EN: out-of-maze coordinates skip the ROM and return 0000.
module maze_port_arbiter (
    input  logic                  clk,
    input  logic                  reset_n,
    maze_port_arbiter_if.slave    bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg;
    logic [1:0] winner_reg;
    logic [9:0] x_reg, y_reg;
    logic [9:0] rom_x_reg, rom_y_reg;
    logic [3:0] rdata_reg;
    logic       oob_reg;

    logic [9:0] req_x [4];
    logic [9:0] req_y [4];
    logic [3:0] rot_req;
    logic [1:0] offset;
    logic [1:0] pick;
    logic       arb_win;
    logic       oob_next;
    logic       rom_en_int;

    assign req_x[0] = bus.req_x0;
    assign req_x[1] = bus.req_x1;
    assign req_x[2] = bus.req_x2;
    assign req_x[3] = bus.req_x3;
    assign req_y[0] = bus.req_y0;
    assign req_y[1] = bus.req_y1;
    assign req_y[2] = bus.req_y2;
    assign req_y[3] = bus.req_y3;

    // Rotate requests so that position 0 is the requester at ptr.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) offset = 2'(i);
        end
    end

    assign pick    = ptr_reg + offset;
    assign arb_win = ((state_reg == IDLE) || (state_reg == RESP)) && (bus.req != 4'b0000);

`ifdef MAZE_ARB_BOUNDS_CHECK_EN
    assign oob_next = (req_x[pick] >= 10'd380) || (req_y[pick] >= 10'd432);
`else
    assign oob_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bus.gnt    = 4'b0000;
        bus.rvalid = 4'b0000;
        rom_en_int = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (arb_win) state_next = ISSUE;
            end
            ISSUE: begin
                bus.gnt    = 4'b0001 << winner_reg;
                rom_en_int = !oob_reg;
                state_next = WAIT;
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                bus.rvalid = 4'b0001 << winner_reg;
                state_next = arb_win ? ISSUE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Coordinates are captured at arbitration so the requester may move on after gnt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg    <= 2'd0;
            winner_reg <= 2'd0;
            x_reg      <= 10'd0;
            y_reg      <= 10'd0;
            oob_reg    <= 1'b0;
            rom_x_reg  <= 10'd0;
            rom_y_reg  <= 10'd0;
            rdata_reg  <= 4'b0000;
        end else begin
            if (arb_win) begin
                winner_reg <= pick;
                x_reg      <= req_x[pick];
                y_reg      <= req_y[pick];
                oob_reg    <= oob_next;
                ptr_reg    <= pick + 2'd1;
            end
            if (rom_en_int) begin
                rom_x_reg <= x_reg;
                rom_y_reg <= y_reg;
            end
            if (state_reg == WAIT) begin
                rdata_reg <= oob_reg ? 4'b0000 : bus.rom_data;
            end
        end
    end

    assign bus.rom_en = rom_en_int;
    assign bus.rom_x  = rom_en_int ? x_reg : rom_x_reg;
    assign bus.rom_y  = rom_en_int ? y_reg : rom_y_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed plus random stimulus for maze_port_arbiter, checked against a
// transaction-level model of arbitration order, latency and ROM contents.
module tb_maze_port_arbiter;

`ifdef MAZE_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    maze_port_arbiter_if bus ();

    maze_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_fn(input logic [9:0] x, input logic [9:0] y);
        return 4'(x[3:0] + y[3:0] + 4'd3);
    endfunction

    // Behavioural intersection ROM: data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_x, bus.rom_y);
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int txn    = 0;

    // Model: age = cycles since the lookup was accepted (99 = nothing in flight).
    int         m_age;
    int         m_ptr;
    int         m_win;
    logic [9:0] m_x, m_y, m_romx, m_romy;
    bit         m_oob;
    logic [3:0] m_rdata;

    logic [3:0] glog [$];
    int         gcyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] get_x(input int i);
        case (i)
            0: return bus.req_x0;
            1: return bus.req_x1;
            2: return bus.req_x2;
            default: return bus.req_x3;
        endcase
    endfunction

    function automatic logic [9:0] get_y(input int i);
        case (i)
            0: return bus.req_y0;
            1: return bus.req_y1;
            2: return bus.req_y2;
            default: return bus.req_y3;
        endcase
    endfunction

    task automatic set_xy(input int i, input logic [9:0] x, input logic [9:0] y);
        case (i)
            0: begin bus.req_x0 = x; bus.req_y0 = y; end
            1: begin bus.req_x1 = x; bus.req_y1 = y; end
            2: begin bus.req_x2 = x; bus.req_y2 = y; end
            default: begin bus.req_x3 = x; bus.req_y3 = y; end
        endcase
    endtask

    task automatic model_reset();
        m_age   = 99;
        m_ptr   = 0;
        m_win   = 0;
        m_x     = '0;
        m_y     = '0;
        m_romx  = '0;
        m_romy  = '0;
        m_oob   = 1'b0;
        m_rdata = 4'b0000;
    endtask

    task automatic check_outputs();
        chk("gnt",    bus.gnt,    (m_age == 1) ? 32'(4'b0001 << m_win) : 32'd0);
        chk("rom_en", bus.rom_en, 32'((m_age == 1) && !m_oob));
        chk("rvalid", bus.rvalid, (m_age == 3) ? 32'(4'b0001 << m_win) : 32'd0);
        chk("rdata",  bus.rdata,  m_rdata);
        chk("rom_x",  bus.rom_x,  m_romx);
        chk("rom_y",  bus.rom_y,  m_romy);
        chk("busy",   bus.busy,   32'(m_age <= 3));
    endtask

    // One clock: predict from inputs present before the edge, then compare after it.
    task automatic step();
        logic [3:0] r;
        bit         arb;
        int         w;
        logic [9:0] px, py;
        r   = bus.req;
        arb = (m_age >= 3) && (r != 4'b0000);
        w   = 0;
        for (int k = 3; k >= 0; k--) begin
            if (r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        px = get_x(w);
        py = get_y(w);
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else if (arb) begin
            m_win = w;
            m_x   = px;
            m_y   = py;
            m_oob = BOUNDS && ((px >= 10'd380) || (py >= 10'd432));
            m_ptr = (w + 1) % 4;
            m_age = 1;
            if (!m_oob) begin
                m_romx = px;
                m_romy = py;
            end
        end else begin
            if (m_age == 2) m_rdata = m_oob ? 4'b0000 : rom_fn(m_x, m_y);
            if (m_age < 99) m_age++;
        end
        check_outputs();
        if (bus.gnt != 4'b0000) begin
            glog.push_back(bus.gnt);
            gcyc.push_back(cyc);
        end
        if (m_age == 3) begin
            txn++;
            $display("txn %0d: cycle %0d requester %0d x=%0d y=%0d rvalid=%b rdata=%b",
                     txn, cyc, m_win, m_x, m_y, bus.rvalid, bus.rdata);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        bus.req = 4'b0000;
        steps(4);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) set_xy(i, 10'(10 * i + 5), 10'(20 * i + 7));
        model_reset();

        // Reset state
        steps(2);
        #2 reset_n = 1'b1;

        // Single request, known ROM contents
        bus.req = 4'b0001;
        set_xy(0, 10'd276, 10'd430);
        step();
        chk("r030_gnt", bus.gnt, 4'b0001);
        chk("r030_rom_x", bus.rom_x, 10'd276);
        chk("r030_rom_y", bus.rom_y, 10'd430);
        bus.req = 4'b0000;
        set_xy(0, 10'd3, 10'd4);
        steps(2);
        chk("r030_rvalid", bus.rvalid, 4'b0001);
        chk("r030_rdata", bus.rdata, 4'b0101);
        steps(2);

        // All four requesting continuously from reset
        reset_n = 1'b0;
        step();
        #2 reset_n = 1'b1;
        glog.delete();
        gcyc.delete();
        bus.req = 4'b1111;
        steps(13);
        chk("r031_ngrants", glog.size(), 5);
        if (glog.size() >= 5) begin
            chk("r031_g0", glog[0], 4'b0001);
            chk("r031_g1", glog[1], 4'b0010);
            chk("r031_g2", glog[2], 4'b0100);
            chk("r031_g3", glog[3], 4'b1000);
            chk("r031_g4", glog[4], 4'b0001);
            for (int i = 1; i < 5; i++) chk("r031_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        drain();

        // Wrap and skip: bring ptr to 3, then 0110 grants requester 1
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        steps(2);
        bus.req = 4'b0110;
        step();
        chk("r032_gnt", bus.gnt, 4'b0010);
        drain();

        // Held request: requester 0 holds through RESP while 2 waits
        bus.req = 4'b1000;
        step();
        drain();
        bus.req = 4'b0101;
        step();
        chk("r035_first", bus.gnt, 4'b0001);
        steps(3);
        chk("r035_second", bus.gnt, 4'b0100);
        steps(3);
        chk("r035_third", bus.gnt, 4'b0001);
        drain();

        // Reset during WAIT
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        step();
        reset_n = 1'b0;
        #1;
        chk("r033_gnt", bus.gnt, 0);
        chk("r033_rvalid", bus.rvalid, 0);
        chk("r033_rdata", bus.rdata, 0);
        chk("r033_rom_en", bus.rom_en, 0);
        chk("r033_rom_x", bus.rom_x, 0);
        chk("r033_rom_y", bus.rom_y, 0);
        chk("r033_busy", bus.busy, 0);
        model_reset();
        steps(2);
        reset_n = 1'b1;
        steps(4);
        bus.req = 4'b0001;
        set_xy(0, 10'd100, 10'd200);
        step();
        chk("r033_regrant", bus.gnt, 4'b0001);
        drain();

        // Out-of-range column
        bus.req = 4'b0001;
        set_xy(0, 10'd500, 10'd10);
        step();
        chk("r034_gnt", bus.gnt, 4'b0001);
        chk("r034_rom_en", bus.rom_en, BOUNDS ? 0 : 1);
        bus.req = 4'b0000;
        steps(2);
        chk("r034_rvalid", bus.rvalid, 4'b0001);
        chk("r034_rdata", bus.rdata, BOUNDS ? 32'd0 : 32'(rom_fn(10'd500, 10'd10)));
        drain();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) bus.req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_xy(i, 10'($urandom_range(0, 520)), 10'($urandom_range(0, 520)));
            end
            if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            step();
        end
        reset_n = 1'b1;
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
